// File: rtl/gfx_scan_sink_if.sv
// rtl/gfx_scan_sink_if.sv - rgb30 scanout stream bundle between the scanout path and gfx_scan_sink
// Purpose: groups the Avalon-ST style pixel stream into one port.
// Signals:
//   scan_valid          source -> sink  beat valid
//   scan_startofpacket  source -> sink  first pixel of a frame
//   scan_endofpacket    source -> sink  last pixel of a frame
//   scan_data[29:0]     source -> sink  {r[9:0], g[9:0], b[9:0]}
//   scan_ready          sink -> source  beat taken this cycle when scan_valid=1
// Modports: master = stream source, slave = gfx_scan_sink.
interface gfx_scan_sink_if;
    logic        scan_valid;
    logic        scan_startofpacket;
    logic        scan_endofpacket;
    logic [29:0] scan_data;
    logic        scan_ready;

    modport master (
        output scan_valid,
        output scan_startofpacket,
        output scan_endofpacket,
        output scan_data,
        input  scan_ready
    );

    modport slave (
        input  scan_valid,
        input  scan_startofpacket,
        input  scan_endofpacket,
        input  scan_data,
        output scan_ready
    );
endinterface

// File: rtl/gfx_scan_sink.sv
// rtl/gfx_scan_sink.sv - scanout stream to VGA timing sink with frame lock and underrun detection
// Purpose: consumes the rgb30 frame stream and drives VGA hsync/vsync/blank and 8-bit RGB.
//   A clock-enable divider produces the pixel tick; h/v counters produce the raster.
//   RESYNC drains the stream until an SOP beat lines up with raster origin, then STREAM
//   consumes one beat per active tick and checks SOP/EOP framing.
// Optional: define GFX_SCAN_UNDERRUN_CNT_EN to add the saturating underrun_count output.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   scan              stream slave (gfx_scan_sink_if.slave)
//   vsync             one-clk pulse at start of vertical sync
//   vga_r/g/b         registered 8-bit colour
//   vga_hsync_n       active-low hsync, aligned with the pixel
//   vga_vsync_n       active-low vsync, aligned with the pixel
//   vga_blank_n       low outside the active region
//   underrun          sticky starvation flag, cleared on the next lock
//   underrun_count    (GFX_SCAN_UNDERRUN_CNT_EN only) starved active ticks, saturating
module gfx_scan_sink #(
    parameter int unsigned CLK_DIV        = 2,
    parameter int unsigned H_ACTIVE       = 640,
    parameter int unsigned H_FP           = 16,
    parameter int unsigned H_SYNC         = 96,
    parameter int unsigned H_BP           = 48,
    parameter int unsigned V_ACTIVE       = 480,
    parameter int unsigned V_FP           = 10,
    parameter int unsigned V_SYNC         = 2,
    parameter int unsigned V_BP           = 33,
    parameter logic [23:0] UNDERRUN_COLOR = 24'h000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gfx_scan_sink_if.slave        scan,
    output logic                  vsync,
    output logic [7:0]            vga_r,
    output logic [7:0]            vga_g,
    output logic [7:0]            vga_b,
    output logic                  vga_hsync_n,
    output logic                  vga_vsync_n,
    output logic                  vga_blank_n,
    output logic                  underrun
`ifdef GFX_SCAN_UNDERRUN_CNT_EN
    ,
    output logic [15:0]           underrun_count
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL + 1);
    localparam int unsigned VW      = $clog2(V_TOTAL + 1);
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] H_PX_END = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_PX_END = VW'(V_ACTIVE - 1);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [0:0] ST_RESYNC = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [DW-1:0] r_div;
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic [0:0]    r_state;
    logic          r_underrun;
    logic          r_vsync;
    logic          r_hsync_n;
    logic          r_vsync_n;
    logic          r_blank_n;
    logic [23:0]   r_rgb;

    logic          w_tick;
    logic          w_active;
    logic          w_origin;
    logic          w_last_px;
    logic          w_hs;
    logic          w_vs;
    logic          w_sop_pending;
    logic          w_lock;
    logic          w_stream_tick;
    logic          w_starve;
    logic          w_frame_err;
    logic          w_ready;
    logic          w_take_pixel;
    logic [23:0]   w_pix_rgb;
    logic          w_unused;

    assign w_tick    = (r_div == DIV_LAST);
    assign w_active  = (r_h < H_ACT) && (r_v < V_ACT);
    assign w_origin  = (r_h == '0) && (r_v == '0);
    assign w_last_px = (r_h == H_PX_END) && (r_v == V_PX_END);
    assign w_hs      = (r_h >= HS_BEG) && (r_h < HS_END);
    assign w_vs      = (r_v >= VS_BEG) && (r_v < VS_END);

    assign w_sop_pending = scan.scan_valid && scan.scan_startofpacket;
    // Lock only when the held SOP beat lines up with the raster origin.
    assign w_lock        = (r_state == ST_RESYNC) && w_tick && w_origin && w_sop_pending;
    assign w_stream_tick = (r_state == ST_STREAM) && w_tick && w_active;
    assign w_starve      = w_stream_tick && !scan.scan_valid;

    // Framing check on each streamed slot: SOP only at origin, EOP exactly at the last pixel.
    assign w_frame_err = w_stream_tick && (
        (scan.scan_valid &&  scan.scan_startofpacket && !w_origin) ||
        (scan.scan_valid && !scan.scan_startofpacket &&  w_origin) ||
        (scan.scan_valid &&  scan.scan_endofpacket   && !w_last_px) ||
        (w_last_px && !(scan.scan_valid && scan.scan_endofpacket)));

    // RESYNC drains non-SOP beats every cycle but holds an SOP beat until lock.
    always_comb begin
        w_ready = 1'b0;
        if (rst_n) begin
            if (r_state == ST_RESYNC) begin
                w_ready = !w_sop_pending || w_lock;
            end else begin
                w_ready = w_tick && w_active;
            end
        end
    end

    assign scan.scan_ready = w_ready;

    assign w_take_pixel = scan.scan_valid && w_ready && (w_stream_tick || w_lock);
    assign w_pix_rgb    = {scan.scan_data[29:22], scan.scan_data[19:12], scan.scan_data[9:2]};
    assign w_unused     = ^{scan.scan_data[21:20], scan.scan_data[11:10], scan.scan_data[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div <= '0;
            r_h   <= '0;
            r_v   <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DW'(1);
            if (w_tick) begin
                if (r_h == H_LAST) begin
                    r_h <= '0;
                    r_v <= (r_v == V_LAST) ? '0 : r_v + VW'(1);
                end else begin
                    r_h <= r_h + HW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RESYNC;
            r_underrun <= 1'b0;
        end else begin
            if (r_state == ST_RESYNC) begin
                if (w_lock) begin
                    r_state <= ST_STREAM;
                end
            end else if (w_frame_err) begin
                r_state <= ST_RESYNC;
            end
            // Set has priority over the clear at lock.
            if (w_starve) begin
                r_underrun <= 1'b1;
            end else if (w_lock) begin
                r_underrun <= 1'b0;
            end
        end
    end

    // Pixel and sync outputs share one register stage so they stay aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vsync   <= 1'b0;
            r_hsync_n <= 1'b1;
            r_vsync_n <= 1'b1;
            r_blank_n <= 1'b0;
            r_rgb     <= '0;
        end else begin
            r_vsync <= w_tick && (r_h == '0) && (r_v == VS_BEG);
            if (w_tick) begin
                r_hsync_n <= !w_hs;
                r_vsync_n <= !w_vs;
                r_blank_n <= w_active;
                if (!w_active) begin
                    r_rgb <= '0;
                end else if (w_take_pixel) begin
                    r_rgb <= w_pix_rgb;
                end else begin
                    r_rgb <= UNDERRUN_COLOR;
                end
            end
        end
    end

`ifdef GFX_SCAN_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_underrun_count <= '0;
        end else if (w_starve && (r_underrun_count != 16'hFFFF)) begin
            r_underrun_count <= r_underrun_count + 16'd1;
        end
    end

    assign underrun_count = r_underrun_count;
`endif

    assign vsync       = r_vsync;
    assign vga_r       = r_rgb[23:16];
    assign vga_g       = r_rgb[15:8];
    assign vga_b       = r_rgb[7:0];
    assign vga_hsync_n = r_hsync_n;
    assign vga_vsync_n = r_vsync_n;
    assign vga_blank_n = r_blank_n;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_gfx_scan_sink.sv
// tb/tb_gfx_scan_sink.sv - directed self-checking bench for gfx_scan_sink on a 16x8 raster
module tb_gfx_scan_sink;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync_n, vga_vsync_n, vga_blank_n;
    logic        underrun;
`ifdef GFX_SCAN_UNDERRUN_CNT_EN
    logic [15:0] underrun_count;
`endif

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gfx_scan_sink_if scan();

    // Raster: H 8+2+3+3 = 16, V 4+1+2+1 = 8, two clk per pixel -> 256 clk per frame.
    gfx_scan_sink #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .UNDERRUN_COLOR(24'hA5A5A5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .scan(scan),
        .vsync(vsync),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .vga_hsync_n(vga_hsync_n),
        .vga_vsync_n(vga_vsync_n),
        .vga_blank_n(vga_blank_n),
        .underrun(underrun)
`ifdef GFX_SCAN_UNDERRUN_CNT_EN
        ,
        .underrun_count(underrun_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] mk(input int p);
        logic [7:0] b;
        b = p[7:0];
        return {b, 2'b00, ~b, 2'b01, b ^ 8'h5A, 2'b10};
    endfunction

    function automatic logic [23:0] px(input int p);
        logic [7:0] b;
        b = p[7:0];
        return {b, ~b, b ^ 8'h5A};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge, t = that edge number.
    task automatic send(input int p, input bit sop, input bit eop, input bit chkpix, output int t);
        bit r;
        int n;
        scan.scan_valid         = 1'b1;
        scan.scan_startofpacket = sop;
        scan.scan_endofpacket   = eop;
        scan.scan_data          = mk(p);
        r = 1'b0;
        n = 0;
        while (!r && n < 1000) begin
            @(negedge clk);
            r = scan.scan_ready;
            @(posedge clk);
            #1;
            n++;
        end
        scan.scan_valid = 1'b0;
        t = cyc;
        chk("accept_in_budget", {31'd0, r}, 32'd1);
        if (chkpix) begin
            chk("pixel_rgb", {8'd0, vga_r, vga_g, vga_b}, {8'd0, px(p)});
            chk("pixel_blank_n", {31'd0, vga_blank_n}, 32'd1);
        end
    endtask

    initial begin
        int n0, m, t, tv0, tv1, nv, nhs, nvs, nbl;
        scan.scan_valid         = 1'b0;
        scan.scan_startofpacket = 1'b0;
        scan.scan_endofpacket   = 1'b0;
        scan.scan_data          = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, scan.scan_ready}, 32'd0);
        chk("rst_vsync", {31'd0, vsync}, 32'd0);
        chk("rst_hsync_n", {31'd0, vga_hsync_n}, 32'd1);
        chk("rst_vsync_n", {31'd0, vga_vsync_n}, 32'd1);
        chk("rst_blank_n", {31'd0, vga_blank_n}, 32'd0);
        chk("rst_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
`ifdef GFX_SCAN_UNDERRUN_CNT_EN
        chk("rst_count", {16'd0, underrun_count}, 32'd0);
`endif
        n0 = cyc;
        rst_n = 1'b1;

        // Raster timing over exactly two frames (512 clk)
        tv0 = -1; tv1 = -1; nv = 0; nhs = 0; nvs = 0; nbl = 0;
        repeat (512) begin
            @(negedge clk);
            if (vsync) begin
                if (tv0 < 0) tv0 = cyc; else tv1 = cyc;
                nv++;
                chk("vsync_n_at_pulse", {31'd0, vga_vsync_n}, 32'd0);
            end
            if (!vga_hsync_n) nhs++;
            if (!vga_vsync_n) nvs++;
            if (vga_blank_n) nbl++;
        end
        chk("vsync_pulse_clks", nv, 2);
        chk("vsync_period", tv1 - tv0, 256);
        chk("hsync_low_clks", nhs, 96);
        chk("vsync_low_clks", nvs, 128);
        chk("blank_high_clks", nbl, 128);
        chk("idle_no_underrun", {31'd0, underrun}, 32'd0);
        @(posedge clk);
        #1;

        // Three aligned frames, continuous valid
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < 32; p++) begin
                send(p, p == 0, p == 31, 1'b1, t);
                if (p == 0) chk("frame_lock_edge", t - n0, 514 + 256 * f);
                if (f == 0 && p == 31) chk("last_px_edge", t - n0, 624);
            end
        end
        chk("clean_no_underrun", {31'd0, underrun}, 32'd0);
        scan.scan_valid = 1'b1; scan.scan_startofpacket = 1'b0; scan.scan_endofpacket = 1'b0;
        @(negedge clk);
        chk("stream_blank_ready", {31'd0, scan.scan_ready}, 32'd0);
        @(posedge clk);
        #1;
        scan.scan_valid = 1'b0;

        // Frame 3: starve 5 ticks on line 1 after pixel 9
        for (int p = 0; p < 10; p++) send(p, p == 0, 1'b0, 1'b1, t);
        repeat (5) begin
            repeat (2) @(posedge clk);
            #1;
            chk("starve_color", {8'd0, vga_r, vga_g, vga_b}, 32'h00A5A5A5);
        end
        chk("underrun_set", {31'd0, underrun}, 32'd1);
        for (int p = 10; p < 32; p++) send(p, 1'b0, p == 31, p <= 26, t);
        scan.scan_valid = 1'b1; scan.scan_startofpacket = 1'b0; scan.scan_endofpacket = 1'b0;
        @(negedge clk);
        chk("resync_after_shift", {31'd0, scan.scan_ready}, 32'd1);
        @(posedge clk);
        #1;
        scan.scan_valid = 1'b0;
        chk("underrun_sticky", {31'd0, underrun}, 32'd1);
`ifdef GFX_SCAN_UNDERRUN_CNT_EN
        chk("underrun_count5", {16'd0, underrun_count}, 32'd5);
`endif

        // Frame 4: relock clears underrun
        for (int p = 0; p < 32; p++) begin
            send(p, p == 0, p == 31, 1'b1, t);
            if (p == 0) begin
                chk("relock_edge", t - n0, 514 + 256 * 4);
                chk("relock_clears", {31'd0, underrun}, 32'd0);
            end
        end

        // Frame 5: early EOP on pixel 10
        for (int p = 0; p < 11; p++) send(p, p == 0, p == 10, 1'b1, t);
        scan.scan_valid = 1'b1; scan.scan_startofpacket = 1'b0; scan.scan_endofpacket = 1'b0;
        @(negedge clk);
        chk("resync_after_eop", {31'd0, scan.scan_ready}, 32'd1);
        @(posedge clk);
        #1;
        scan.scan_valid = 1'b0;

        // Frame 6: lock, starve one tick, then a one-clk reset mid-line
        for (int p = 0; p < 4; p++) begin
            send(p, p == 0, 1'b0, 1'b1, t);
            if (p == 0) chk("eop_relock_edge", t - n0, 514 + 256 * 6);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_underrun", {31'd0, underrun}, 32'd1);
        scan.scan_valid = 1'b1; scan.scan_startofpacket = 1'b0; scan.scan_endofpacket = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", {31'd0, scan.scan_ready}, 32'd0);
        chk("mid_rst_blank_n", {31'd0, vga_blank_n}, 32'd0);
        chk("mid_rst_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
        chk("mid_rst_underrun", {31'd0, underrun}, 32'd0);
        chk("mid_rst_syncs", {30'd0, vga_hsync_n, vga_vsync_n}, 32'd3);
`ifdef GFX_SCAN_UNDERRUN_CNT_EN
        chk("mid_rst_count", {16'd0, underrun_count}, 32'd0);
`endif
        m = cyc;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_drain", {31'd0, scan.scan_ready}, 32'd1);
        @(posedge clk);
        #1;
        scan.scan_valid = 1'b0;
        send(0, 1'b1, 1'b0, 1'b1, t);
        chk("post_rst_lock_edge", t - m, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gfx_scan_sink.md
Name: gfx_scan_sink

Overview:
- Consumes the rgb30 Avalon-ST pixel stream produced by the scanout path and drives VGA-style timing: hsync, vsync, blank and 8-bit RGB.
- Generates the one-cycle vsync pulse that the scanout side uses to release its frame-commit wait.
- Sits between the scanout stream and the board video DAC. Single clock domain; the pixel rate is derived by a clock-enable divider.

Parameters:
- CLK_DIV, 2, clk cycles per pixel tick (>=1)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, hsync width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vsync width, in lines
- V_BP, 33, vertical back porch, in lines
- UNDERRUN_COLOR, 24'h000000, rgb24 value shown when the stream starves

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- scan_valid  in  1  stream beat valid
- scan_startofpacket  in  1  first pixel of frame
- scan_endofpacket  in  1  last pixel of frame
- scan_data  in  30  rgb30 pixel, {r[9:0],g[9:0],b[9:0]}
- scan_ready  out  1  beat accepted this cycle when scan_valid=1
- vsync  out  1  one-clk pulse at start of vertical sync
- vga_r, vga_g, vga_b  out  8 each  pixel colour, registered
- vga_hsync_n, vga_vsync_n  out  1 each  active-low syncs
- vga_blank_n  out  1  low outside the active region
- underrun  out  1  sticky; set on starvation, cleared at next SOP lock

Behaviour:
- Reset (rst_n=0 at a clk edge), all at once:
  - Counters: tick counter=0, h=0, v=0.
  - State: state=RESYNC.
  - Outputs: scan_ready=0, vsync=0, vga_*sync_n=1, vga_blank_n=0, rgb=0, underrun=0.
  - Reset mid-frame discards any partial line.
- Tick generation:
  - tick=1 when the divider counter reaches CLK_DIV-1, then the counter wraps to 0. With CLK_DIV=1, tick is always 1.
- Counters:
  - h advances on tick and wraps at H_TOTAL-1, where H_TOTAL = sum of the H_* parameters. On h wrap, v advances and wraps at V_TOTAL-1.
  - Active region: h<H_ACTIVE and v<V_ACTIVE.
- Sync generation:
  - hsync_n=0 for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync_n likewise over v, using the V_* parameters.
- vsync pulse:
  - vsync=1 for exactly one clk, on the tick where v enters V_ACTIVE+V_FP at h=0.
- Stream acceptance:
  - Combinational: scan_ready = tick && active && state==STREAM, or state==RESYNC (drain).
  - Ready latency 0.
- States:
  - RESYNC:
    - scan_ready=1 every cycle. Beats without SOP are dropped.
    - A beat with SOP is not consumed. scan_ready is forced 0 for that beat, so it is held until STREAM.
    - The SOP is taken only when the display reaches h=0,v=0 on a tick. Until then, scan_ready=0 whenever scan_valid && scan_startofpacket.
    - Lock: at h=0,v=0 on a tick with an SOP beat pending, go to STREAM and consume it as pixel (0,0).
  - STREAM:
    - Each active tick consumes one beat.
    - If scan_valid=0 on an active tick: emit UNDERRUN_COLOR, set underrun, stay in STREAM. The pixel slot is lost, so data shifts; this is resolved by the EOP check.
    - If SOP is seen at any pixel other than (0,0), or EOP at any pixel other than the last (H_ACTIVE-1, V_ACTIVE-1), or EOP is missing at the last pixel: go to RESYNC after the current beat.
    - On the last pixel carrying EOP: stay in STREAM. The next frame's SOP is required at (0,0).
  - Lock clears underrun on the SOP acceptance cycle. If an underrun occurs in the same cycle, set wins.
- Pixel output:
  - Registered, one clk after acceptance: vga_r = scan_data[29:22], vga_g = [19:12], vga_b = [9:2].
  - vga_blank_n, vga_hsync_n and vga_vsync_n are delayed by the same single register, so they stay aligned with the pixel.
  - Outside the active region, rgb=0. Outputs hold between ticks.
- Simultaneous events:
  - Reset dominates everything.
  - An EOP error and an underrun in the same frame leave underrun set until the next lock.

Optional Feature:
- Macro: GFX_SCAN_UNDERRUN_CNT_EN.
- Defined:
  - Adds output port underrun_count, 16 bits.
  - Counts starved active ticks; saturates at 16'hFFFF.
  - Cleared only by reset, not by lock.
- Undefined:
  - Port absent. Underrun reporting is the sticky flag only.

Test Plan:
- Reset checks, CLK_DIV=2, default timing:
  - Counter period: vsync pulses every 800*525*2 = 840000 clk.
  - hsync_n low for 192 clk per line.
  - vga_blank_n high exactly 640*2 clk per active line.
- Continuous valid stream of 307200 beats, SOP on the first, EOP on the last, data = pixel index:
  - Pixel (0,0) outputs rgb from data 0.
  - (639,479) is consumed on its tick.
  - No underrun; state stays STREAM across 3 frames.
- Stream starts mid-frame with non-SOP beats:
  - All beats dropped with scan_ready=1.
  - The SOP beat is held (scan_ready=0) until h=0,v=0, then accepted.
- Drop scan_valid for 5 active ticks on line 10:
  - underrun=1; UNDERRUN_COLOR output on those 5 pixels.
  - EOP misaligned -> RESYNC; relock at the next frame clears underrun.
  - With GFX_SCAN_UNDERRUN_CNT_EN: underrun_count=5.
- EOP asserted on pixel 100 of frame: RESYNC after that beat; next SOP locks at (0,0).
- Assert rst_n=0 mid-line for 1 clk:
  - All outputs reach reset values on the next edge.
  - h,v restart from 0; SOP is required again.
